// File: rtl/snake_engine_if.sv
// Pixel, button and status bundle between the VGA/board side and the snake engine.
interface snake_engine_if;
  logic       bright;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       btnC;
  logic       btnU;
  logic       btnD;
  logic       btnL;
  logic       btnR;
  logic [7:0] rgb;
  logic [15:0] score;
  logic       game_over;

  modport master (
    output bright, hCount, vCount, btnC, btnU, btnD, btnL, btnR,
    input  rgb, score, game_over
  );

  modport slave (
    input  bright, hCount, vCount, btnC, btnU, btnD, btnL, btnR,
    output rgb, score, game_over
  );
endinterface

// File: rtl/snake_engine.sv
// Snake game core: body, food, score and game FSM on a cell grid, plus per-pixel colouring.
module snake_engine #(
  parameter int unsigned GRID_W    = 32,
  parameter int unsigned GRID_H    = 24,
  parameter int unsigned CELL_LOG2 = 4,
  parameter int unsigned H_OFFSET  = 144,
  parameter int unsigned V_OFFSET  = 35,
  parameter int unsigned MAX_LEN   = 64,
  parameter int unsigned GROW      = 4,
  parameter int unsigned TICK_DIV  = 10_000_000
) (
  input logic            clk,
  input logic            reset,
  snake_engine_if.slave  bus
);
  localparam int unsigned XW = $clog2(GRID_W);
  localparam int unsigned YW = $clog2(GRID_H);
  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StReloc, StDead} stateT;
  typedef enum logic [1:0] {DirUp, DirDown, DirLeft, DirRight} dirT;

  stateT          state;
  dirT            dir, nextDir, req;
  logic [XW-1:0]  segX [MAX_LEN];
  logic [YW-1:0]  segY [MAX_LEN];
  logic [LW-1:0]  len, growPending, lenNext, gpNext;
  logic [XW-1:0]  foodX, nhX, candX, pixX;
  logic [YW-1:0]  foodY, nhY, candY, pixY;
  logic [15:0]    lfsr, score;
  logic [TW-1:0]  tickCnt;
  logic [7:0]     rgb, rgbNext;
  logic [XW:0]    rawX, wrapX;
  logic [YW:0]    rawY, wrapY;
  logic [9:0]     hRel, vRel, cx, cy;
  logic           tick, hitWall, hitSelf, ateFood, candOnBody, reqValid, restart;
  logic           inField, isHead, isBody, isFood;
  int unsigned    gpSum;

  assign tick    = (state == StRun) && (tickCnt == TW'(TICK_DIV - 1));
  assign restart = reset || (state == StDead && bus.btnC);

  // Candidate head; a step off the grid is flagged instead of wrapping.
  always_comb begin
    nhX = segX[0];
    nhY = segY[0];
    hitWall = 1'b0;
    unique case (nextDir)
      DirUp:    if (segY[0] == '0) hitWall = 1'b1; else nhY = segY[0] - 1'b1;
      DirDown:  if (segY[0] == YW'(GRID_H - 1)) hitWall = 1'b1; else nhY = segY[0] + 1'b1;
      DirLeft:  if (segX[0] == '0) hitWall = 1'b1; else nhX = segX[0] - 1'b1;
      DirRight: if (segX[0] == XW'(GRID_W - 1)) hitWall = 1'b1; else nhX = segX[0] + 1'b1;
    endcase
  end

  always_comb begin
    hitSelf = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      // The tail cell is free to enter when it vacates on this same tick.
      if (LW'(i) < len && !(LW'(i) == len - 1'b1 && growPending == '0) &&
          segX[i] == nhX && segY[i] == nhY) hitSelf = 1'b1;
    end
  end

  assign ateFood = (nhX == foodX) && (nhY == foodY);

  always_comb begin
    lenNext = len;
    gpNext  = growPending;
    if (growPending != '0 && len < LW'(MAX_LEN)) begin
      lenNext = len + 1'b1;
      gpNext  = growPending - 1'b1;
    end
    if (lenNext == LW'(MAX_LEN)) gpNext = '0;
    gpSum = 32'(gpNext) + GROW;
    if (ateFood) gpNext = (gpSum >= MAX_LEN) ? LW'(MAX_LEN) : LW'(gpSum);
  end

  always_comb begin
    reqValid = 1'b1;
    if (bus.btnU)      req = DirUp;
    else if (bus.btnD) req = DirDown;
    else if (bus.btnL) req = DirLeft;
    else if (bus.btnR) req = DirRight;
    else begin
      req      = nextDir;
      reqValid = 1'b0;
    end
  end

  assign rawX  = {1'b0, lfsr[XW-1:0]};
  assign wrapX = (rawX >= (XW+1)'(GRID_W)) ? rawX - (XW+1)'(GRID_W) : rawX;
  assign candX = wrapX[XW-1:0];
  assign rawY  = {1'b0, lfsr[15 -: YW]};
  assign wrapY = (rawY >= (YW+1)'(GRID_H)) ? rawY - (YW+1)'(GRID_H) : rawY;
  assign candY = wrapY[YW-1:0];

  always_comb begin
    candOnBody = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LW'(i) < len && segX[i] == candX && segY[i] == candY) candOnBody = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3]};
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      state       <= StIdle;
      dir         <= DirRight;
      nextDir     <= DirRight;
      len         <= LW'(1);
      growPending <= '0;
      foodX       <= XW'(GRID_W / 4);
      foodY       <= YW'(GRID_H / 4);
      score       <= '0;
      tickCnt     <= '0;
      for (int i = 0; i < MAX_LEN; i++) begin
        segX[i] <= '0;
        segY[i] <= '0;
      end
      segX[0] <= XW'(GRID_W / 2);
      segY[0] <= YW'(GRID_H / 2);
    end else begin
      if (reqValid && !(len > LW'(1) && req == dirT'(dir ^ 2'b01))) nextDir <= req;
      if (state == StRun) tickCnt <= tick ? '0 : tickCnt + 1'b1;
      else                tickCnt <= '0;
      unique case (state)
        StIdle: if (bus.btnC) state <= StRun;
        StRun: begin
          if (tick) begin
            dir <= nextDir;
            if (hitWall || hitSelf) begin
              state <= StDead;
            end else begin
              for (int i = MAX_LEN - 1; i > 0; i--) begin
                segX[i] <= segX[i-1];
                segY[i] <= segY[i-1];
              end
              segX[0]     <= nhX;
              segY[0]     <= nhY;
              len         <= lenNext;
              growPending <= gpNext;
              if (ateFood) begin
                score <= score + 1'b1;
                state <= StReloc;
              end
            end
          end
        end
        StReloc: begin
          if (!candOnBody) begin
            foodX <= candX;
            foodY <= candY;
            state <= StRun;
          end
        end
        StDead: ;
      endcase
    end
  end

  assign hRel = bus.hCount - 10'(H_OFFSET);
  assign vRel = bus.vCount - 10'(V_OFFSET);
  assign cx   = hRel >> CELL_LOG2;
  assign cy   = vRel >> CELL_LOG2;
  assign pixX = cx[XW-1:0];
  assign pixY = cy[YW-1:0];
  assign inField = (bus.hCount >= 10'(H_OFFSET)) && (bus.vCount >= 10'(V_OFFSET)) &&
                   (cx < 10'(GRID_W)) && (cy < 10'(GRID_H));
  assign isHead = (segX[0] == pixX) && (segY[0] == pixY);
  assign isFood = (foodX == pixX) && (foodY == pixY);

  always_comb begin
    isBody = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if (LW'(i) < len && segX[i] == pixX && segY[i] == pixY) isBody = 1'b1;
    end
  end

  always_comb begin
    rgbNext = 8'h00;
    if (bus.bright && inField) begin
      if (isHead)      rgbNext = 8'hFF;
      else if (isBody) rgbNext = (state == StDead) ? 8'hE0 : 8'h1C;
      else if (isFood) rgbNext = 8'hE0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rgb <= 8'h00;
    else       rgb <= rgbNext;
  end

  assign bus.rgb       = rgb;
  assign bus.score     = score;
  assign bus.game_over = (state == StDead);
endmodule

// File: tb/tb_snake_engine.sv
// Directed bench: dutA grows by 3 per food, dutB (MAX_LEN=8, GROW=10) shares stimulus to hit limits.
module tb_snake_engine;
  logic clk = 1'b0;
  logic reset;
  int   testsRun = 0;
  int   testsFailed = 0;

  always #5 clk = ~clk;

  snake_engine_if busA ();
  snake_engine_if busB ();

  assign busB.bright = busA.bright;
  assign busB.hCount = busA.hCount;
  assign busB.vCount = busA.vCount;
  assign busB.btnC   = busA.btnC;
  assign busB.btnU   = busA.btnU;
  assign busB.btnD   = busA.btnD;
  assign busB.btnL   = busA.btnL;
  assign busB.btnR   = busA.btnR;

  snake_engine #(.TICK_DIV(4), .GROW(3)) dutA (.clk(clk), .reset(reset), .bus(busA));
  snake_engine #(.TICK_DIV(4), .GROW(10), .MAX_LEN(8)) dutB (.clk(clk), .reset(reset), .bus(busB));

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearBtns();
    busA.btnC = 0; busA.btnU = 0; busA.btnD = 0; busA.btnL = 0; busA.btnR = 0;
  endtask

  // Returns 1 time unit after the clock edge on which dutA performs its next tick.
  task automatic waitTick();
    bit seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (dutA.tick) begin
        seen = 1;
        break;
      end
    end
    if (seen) step(1);
    else checkEq("tick_timeout", 0, 1);
  endtask

  task automatic pixelAt(input int cx, input int cy);
    busA.hCount = 10'(144 + cx * 16);
    busA.vCount = 10'(35 + cy * 16);
    busA.bright = 1;
    step(1);
  endtask

  // From IDLE: start heading up, 6 ticks to row 6, then 8 ticks left onto food (8,6).
  task automatic runToFood();
    busA.btnU = 1; busA.btnC = 1;
    step(1);
    busA.btnC = 0;
    repeat (6) waitTick();
    checkEq("up_headX", 32'(dutA.segX[0]), 16);
    checkEq("up_headY", 32'(dutA.segY[0]), 6);
    busA.btnU = 0; busA.btnL = 1;
    repeat (8) waitTick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    clearBtns();
    busA.bright = 0; busA.hCount = 0; busA.vCount = 0;
    step(3);
    reset = 0;
    checkEq("rst_rgb", 32'(busA.rgb), 0);
    checkEq("rst_score", 32'(busA.score), 0);
    checkEq("rst_over", 32'(busA.game_over), 0);
    checkEq("rst_state", 32'(dutA.state), 0);
    checkEq("rst_headX", 32'(dutA.segX[0]), 16);
    checkEq("rst_headY", 32'(dutA.segY[0]), 12);
    checkEq("rst_foodX", 32'(dutA.foodX), 8);
    checkEq("rst_foodY", 32'(dutA.foodY), 6);

    // Straight run right into the wall.
    busA.btnC = 1;
    step(1);
    busA.btnC = 0;
    checkEq("run_state", 32'(dutA.state), 1);
    for (int k = 17; k <= 19; k++) begin
      step(4);
      checkEq("tick_headX", 32'(dutA.segX[0]), k);
    end
    repeat (12) waitTick();
    checkEq("edge_headX", 32'(dutA.segX[0]), 31);
    checkEq("edge_alive", 32'(busA.game_over), 0);
    waitTick();
    checkEq("wall_over", 32'(busA.game_over), 1);
    checkEq("wall_overB", 32'(busB.game_over), 1);
    checkEq("wall_nomove", 32'(dutA.segX[0]), 31);
    pixelAt(31, 12);
    checkEq("dead_head_rgb", 32'(busA.rgb), 32'h FF);
    pixelAt(8, 6);
    checkEq("food_rgb", 32'(busA.rgb), 32'h E0);
    pixelAt(20, 3);
    checkEq("empty_rgb", 32'(busA.rgb), 0);
    busA.hCount = 10'd100;
    step(1);
    checkEq("outside_rgb", 32'(busA.rgb), 0);
    busA.hCount = 10'(144 + 31 * 16);
    busA.bright = 0;
    step(1);
    checkEq("dark_rgb", 32'(busA.rgb), 0);

    // Restart from DEAD, eat the initial food.
    busA.btnC = 1;
    step(1);
    busA.btnC = 0;
    checkEq("restart_state", 32'(dutA.state), 0);
    checkEq("restart_over", 32'(busA.game_over), 0);
    checkEq("restart_headX", 32'(dutA.segX[0]), 16);
    runToFood();
    checkEq("eat_score", 32'(busA.score), 1);
    checkEq("eat_scoreB", 32'(busB.score), 1);
    checkEq("eat_state", 32'(dutA.state), 2);
    checkEq("eat_gp", 32'(dutA.growPending), 3);
    checkEq("eat_gpB_sat", 32'(dutB.growPending), 8);
    for (int c = 0; c < 64 && dutA.state != 1; c++) @(negedge clk);
    checkEq("reloc_done", 32'(dutA.state), 1);
    begin
      int hits = 0;
      for (int i = 0; i < int'(dutA.len); i++)
        if (dutA.segX[i] == dutA.foodX && dutA.segY[i] == dutA.foodY) hits++;
      checkEq("food_off_body", hits, 0);
    end
    waitTick();
    checkEq("grow_len1", 32'(dutA.len), 2);
    repeat (2) waitTick();
    checkEq("grow_len3", 32'(dutA.len), 4);
    checkEq("grow_gp3", 32'(dutA.growPending), 0);
    waitTick();
    checkEq("grow_stop", 32'(dutA.len), 4);
    checkEq("t4_headX", 32'(dutA.segX[0]), 4);

    // Reversal request is ignored, then turn down.
    busA.btnL = 0; busA.btnR = 1;
    waitTick();
    checkEq("rev_headX", 32'(dutA.segX[0]), 3);
    checkEq("rev_headY", 32'(dutA.segY[0]), 6);
    busA.btnR = 0; busA.btnD = 1;
    waitTick();
    checkEq("down_headY", 32'(dutA.segY[0]), 7);
    repeat (2) waitTick();
    checkEq("max_lenB", 32'(dutB.len), 8);
    checkEq("max_gpB", 32'(dutB.growPending), 0);
    checkEq("lenA", 32'(dutA.len), 4);

    // 2x2 loop: dutA enters its vacating tail, dutB hits its own body.
    busA.btnD = 0; busA.btnR = 1;
    waitTick();
    busA.btnR = 0; busA.btnU = 1;
    waitTick();
    busA.btnU = 0; busA.btnL = 1;
    waitTick();
    checkEq("tail_alive", 32'(busA.game_over), 0);
    checkEq("tail_headX", 32'(dutA.segX[0]), 3);
    checkEq("tail_headY", 32'(dutA.segY[0]), 8);
    checkEq("self_overB", 32'(busB.game_over), 1);
    checkEq("self_headB", {16'(dutB.segX[0]), 16'(dutB.segY[0])}, {16'd4, 16'd8});
    pixelAt(4, 9);
    checkEq("body_run_rgb", 32'(busA.rgb), 32'h 1C);
    checkEq("body_dead_rgb", 32'(busB.rgb), 32'h E0);
    pixelAt(4, 8);
    checkEq("head_rgbB", 32'(busB.rgb), 32'h FF);
    checkEq("body_rgbA", 32'(busA.rgb), 32'h 1C);
    clearBtns();

    // Reset lands while dutA is relocating food.
    reset = 1;
    step(2);
    reset = 0;
    runToFood();
    checkEq("pre_rst_reloc", 32'(dutA.state), 2);
    busA.hCount = 10'(144 + 8 * 16);
    busA.vCount = 10'(35 + 6 * 16);
    busA.bright = 1;
    reset = 1;
    step(1);
    reset = 0;
    clearBtns();
    checkEq("reloc_rst_state", 32'(dutA.state), 0);
    checkEq("reloc_rst_score", 32'(busA.score), 0);
    checkEq("reloc_rst_rgb", 32'(busA.rgb), 0);
    checkEq("reloc_rst_over", 32'(busA.game_over), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
